bin_to_bcd_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock.
Accepts a WIDTH-bit unsigned word through a valid/ready handshake and produces DIGITS packed BCD digits plus a one-cycle done strobe.
Flags overflow when the value does not fit in DIGITS decimal digits.
Sits between sensor/ADC sample registers and the seven-segment display drivers on the board designs.

---
 rtl/bin_to_bcd_seq.sv | 123 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Ports: clk, rst (async active-low), in_valid/in_ready/din handshake,
//        done strobe, busy, bcd (DIGITS packed digits), ovf, neg.
// Optional: define BCD_SIGNED_EN to treat din as two's complement.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      din,
    output logic                  done,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  neg
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    scratch;
    logic [BW-1:0]    scr_adj;
    logic [CW-1:0]    cnt;
    logic             sticky;
    logic [WIDTH-1:0] load_val;

`ifdef BCD_SIGNED_EN
    logic load_neg;
    logic neg_pend;

    // A WIDTH-bit magnitude makes -2^(WIDTH-1) come out as 2^(WIDTH-1).
    assign load_neg = din[WIDTH-1];
    assign load_val = load_neg ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;
`else
    assign load_val = din;
    assign neg      = 1'b0;
`endif

    // Per-digit add-3 correction; no carry crosses a digit boundary.
    always_comb begin
        scr_adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                scr_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
`ifdef BCD_SIGNED_EN
            neg      <= 1'b0;
            neg_pend <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= load_val;
                        scratch  <= '0;
                        sticky   <= 1'b0;
                        cnt      <= CW'(WIDTH);
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef BCD_SIGNED_EN
                        neg_pend <= load_neg;
`endif
                    end
                end
                SHIFT: begin
                    // A 1 leaving the top digit means >= 10^DIGITS.
                    scratch <= {scr_adj[BW-2:0], shreg[WIDTH-1]};
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    sticky  <= sticky | scr_adj[BW-1];
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd      <= scratch;
                    ovf      <= sticky;
                    done     <= 1'b1;
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
`ifdef BCD_SIGNED_EN
                    neg      <= neg_pend;
`endif
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: two instances (DIGITS=5 and DIGITS=4)
// driven by the same stimulus and checked against an arithmetic model.
module tb_bin_to_bcd_seq;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] din      = '0;

    logic        rdy5, done5, busy5, ovf5, neg5;
    logic [19:0] bcd5;
    logic        rdy4, done4, busy4, ovf4, neg4;
    logic [15:0] bcd4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy5),
        .din(din), .done(done5), .busy(busy5), .bcd(bcd5),
        .ovf(ovf5), .neg(neg5)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .din(din), .done(done4), .busy(busy4), .bcd(bcd4),
        .ovf(ovf4), .neg(neg4)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic longint unsigned mag(input logic [15:0] v);
`ifdef BCD_SIGNED_EN
        if (v[15]) return 64'd65536 - {48'd0, v};
`endif
        return {48'd0, v};
    endfunction

    function automatic bit sgn(input logic [15:0] v);
`ifdef BCD_SIGNED_EN
        return v[15];
`else
        return 1'b0 & v[0];
`endif
    endfunction

    function automatic logic [19:0] to_bcd(input longint unsigned v,
                                           input int d);
        logic [19:0] r = '0;
        longint unsigned x = v;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit too_big(input longint unsigned v, input int d);
        longint unsigned p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        return v >= p;
    endfunction

    int unsigned     edge_n = 0;
    bit              act    = 1'b0;
    int unsigned     e_acc  = 0;
    longint unsigned p_val  = 0;
    bit              p_neg  = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // A word is taken once the previous one is WIDTH+2 edges old.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            act <= 1'b0;
        end else if (in_valid && (!act || edge_n >= e_acc + 18)) begin
            act   <= 1'b1;
            e_acc <= edge_n;
            p_val <= mag(din);
            p_neg <= sgn(din);
        end
    end

    logic [19:0] h_bcd [2] = '{20'd0, 20'd0};
    bit          h_ovf [2] = '{1'b0, 1'b0};
    bit          h_neg [2] = '{1'b0, 1'b0};
    bit          chk_en = 1'b0;

    task automatic cmp_dut(input int i, input int d, input string tg,
                           input logic dn, input logic bz, input logic rd,
                           input logic [19:0] bc, input logic ov,
                           input logic ng);
        int unsigned n;
        bit          d_exp, b_exp, eo, en;
        logic [19:0] eb;
        n = edge_n - 1;
        if (!rst) begin
            d_exp = 0; b_exp = 0; eb = '0; eo = 0; en = 0;
        end else begin
            d_exp = act && (n == e_acc + 17);
            b_exp = act && (n >= e_acc) && (n <= e_acc + 16);
            if (d_exp) begin
                eb = to_bcd(p_val, d);
                eo = too_big(p_val, d);
                en = p_neg;
            end else begin
                eb = h_bcd[i]; eo = h_ovf[i]; en = h_neg[i];
            end
        end
        h_bcd[i] <= eb;
        h_ovf[i] <= eo;
        h_neg[i] <= en;
        chk({tg, "_done"},  dn, d_exp);
        chk({tg, "_busy"},  bz, b_exp);
        chk({tg, "_ready"}, rd, !b_exp);
        chk({tg, "_bcd"},   bc, eb);
        chk({tg, "_ovf"},   ov, eo);
        chk({tg, "_neg"},   ng, en);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, 5, "d5", done5, busy5, rdy5, bcd5, ovf5, neg5);
            cmp_dut(1, 4, "d4", done4, busy4, rdy4, {4'h0, bcd4},
                    ovf4, neg4);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [15:0] v, output int unsigned hs);
        hs = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        din      = v;
        for (int k = 0; k < 60; k++) begin
            if (rdy5) begin
                hs = edge_n;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: ready never seen for %0h", v);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int unsigned dn_n, output int bz_cnt);
        dn_n   = 0;
        bz_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done5) begin
                dn_n = edge_n - 1;
                return;
            end
            if (busy5) bz_cnt++;
        end
        n_tests++;
        n_fail++;
        $display("FAIL done_timeout: no done within 60 cycles");
    endtask

    int unsigned hs, dn, dn1, dn2;
    int          bz, cnt;

    initial begin
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_bcd5", bcd5, 20'h0);
        chk("rst_ready", rdy5, 1'b1);
        chk("rst_busy", busy5, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        send(16'd0, hs);
        wait_done(dn, bz);
        chk("zero_lat", dn - hs, 32'd17);
        chk("zero_bcd", bcd5, 20'h00000);
        chk("zero_ovf", ovf5, 1'b0);

        send(16'd65535, hs);
        wait_done(dn, bz);
        chk("max_busy_cycles", bz, 32'd17);
        chk("max_bcd5", bcd5, 20'h65535);
        chk("max_ovf5", ovf5, 1'b0);
        chk("max_bcd4", bcd4, 16'h5535);
        chk("max_ovf4", ovf4, 1'b1);

        send(16'd9999, hs);
        wait_done(dn, bz);
        chk("9999_bcd4", bcd4, 16'h9999);
        chk("9999_ovf4", ovf4, 1'b0);

        send(16'd12345, hs);
        wait_done(dn, bz);
        chk("12345_bcd4", bcd4, 16'h2345);
        chk("12345_ovf4", ovf4, 1'b1);
        chk("12345_bcd5", bcd5, 20'h12345);

        // Back-to-back: in_valid stays high through the first conversion.
        send(16'd100, hs);
        in_valid = 1'b1;
        din      = 16'd42;
        wait_done(dn1, bz);
        chk("b2b_first", bcd5, 20'h00100);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(dn2, bz);
        chk("b2b_gap", dn2 - dn1, 32'd18);
        chk("b2b_second", bcd5, 20'h00042);

        // Reset in the middle of a conversion.
        send(16'd500, hs);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_bcd", bcd5, 20'h0);
        chk("midrst_busy", busy5, 1'b0);
        chk("midrst_ready", rdy5, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done5) cnt++;
        end
        chk("midrst_no_done", cnt, 32'd0);
        send(16'd7, hs);
        wait_done(dn, bz);
        chk("after_rst_bcd", bcd5, 20'h00007);

        send(16'h8000, hs);
        wait_done(dn, bz);
`ifdef BCD_SIGNED_EN
        chk("s8000_bcd", bcd5, 20'h32768);
        chk("s8000_neg", neg5, 1'b1);
`else
        chk("u8000_bcd", bcd5, 20'h32768);
        chk("u8000_neg", neg5, 1'b0);
`endif
        send(16'hFFFF, hs);
        wait_done(dn, bz);
`ifdef BCD_SIGNED_EN
        chk("sFFFF_bcd", bcd5, 20'h00001);
        chk("sFFFF_neg", neg5, 1'b1);
`endif
        send(16'h7FFF, hs);
        wait_done(dn, bz);
        chk("7FFF_bcd", bcd5, 20'h32767);
        chk("7FFF_neg", neg5, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
